// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between CPU IO writes and the UART emitter.
//   First-word fall-through: the head byte is always presented on o_tx_data.
//   Optional macro UART_FIFO_OVF_CNT_EN enables a saturating dropped-write counter;
//   without it o_ovf_count is tied to zero.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   i_data, i_valid      CPU byte write (one strobe per byte)
//   o_ready              not full (CPU status busy = !o_ready)
//   o_tx_data/o_tx_valid head byte and not-empty flag toward the emitter
//   i_tx_ready           emitter accepts head byte when o_tx_valid is high
//   i_flush              synchronous clear, priority over push/pop
//   o_level              occupancy 0..DEPTH
//   o_ovf_count          dropped writes while full (saturating at 255)
// DEPTH must be a power of two in 2..256; AW is derived and not overridden.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    input  logic          i_flush,
    output logic [AW:0]   o_level,
    output logic [7:0]    o_ovf_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Status derived only from registered occupancy
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = i_valid & ~w_full;
    assign w_pop   = ~w_empty & i_tx_ready;

    assign o_ready    = ~w_full;
    assign o_tx_valid = ~w_empty;
    assign o_level    = r_level;
    assign o_tx_data  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef UART_FIFO_OVF_CNT_EN
    logic [7:0] r_ovf_count;
    logic       w_drop;

    assign w_drop = i_valid & w_full;

    // Saturating count of writes dropped while full
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf_count <= '0;
        end else if (i_flush) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign o_ovf_count = r_ovf_count;
`else
    assign o_ovf_count = '0;
`endif

endmodule
